// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// drives datapath strobes, traps on bad opcodes or memory timeouts, counts retirements.
module control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        cfsm__pc_update,
  output logic        cfsm__pc_src,
  output logic        cfsm__ir_write,
  output logic        cfsm__reg_write,
  output logic        cfsm__mem_read,
  output logic        cfsm__mem_write,
  output logic        cfsm__alu_src_a,
  output logic [1:0]  cfsm__alu_src_b,
  output logic [1:0]  cfsm__alu_op,
  output logic [1:0]  cfsm__result_src,
  output logic        illegal_instr,
  output logic        bus_error,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  // The wait that would make the counter reach MEM_TIMEOUT is the last one allowed.
  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic        isLoad_q, isLoad_d;
  logic        illegal_q, illegal_d;
  logic        busErr_q, busErr_d;
  logic [31:0] retired_q;

  logic       pcUpdate, pcSrc, irWrite, regWrite, memRead, memWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, resultSrc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      waitCnt_q <= 8'd0;
      isLoad_q  <= 1'b0;
      illegal_q <= 1'b0;
      busErr_q  <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      isLoad_q  <= isLoad_d;
      illegal_q <= illegal_d;
      busErr_q  <= busErr_d;
      if (pcUpdate) retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = 8'd0;
    isLoad_d  = isLoad_q;
    illegal_d = illegal_q;
    busErr_d  = busErr_q;
    pcUpdate  = 1'b0;
    pcSrc     = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'd0;
    aluOp     = 2'd0;
    resultSrc = 2'd0;
    unique case (state_q)
      S_FETCH: begin
        irWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD:   begin state_d = S_MEM_ADDR; isLoad_d = 1'b1; end
          OP_STORE:  begin state_d = S_MEM_ADDR; isLoad_d = 1'b0; end
          OP_RTYPE:  state_d = S_EXEC_R;
          OP_ITYPE:  state_d = S_EXEC_I;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          default:   begin state_d = S_TRAP; illegal_d = 1'b1; end
        endcase
      end
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'd1;
        state_d = isLoad_q ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (waitCnt_q == LAST_WAIT) begin
          state_d  = S_TRAP;
          busErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      S_MEM_WB: begin
        regWrite  = 1'b1;
        resultSrc = 2'd1;
        pcUpdate  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_WRITE: begin
        memWrite = 1'b1;
        if (mem_ready) begin
          pcUpdate = 1'b1;
          state_d  = S_FETCH;
        end else if (waitCnt_q == LAST_WAIT) begin
          state_d  = S_TRAP;
          busErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      S_EXEC_R: begin
        aluSrcA = 1'b1;
        aluOp   = 2'd2;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'd1;
        aluOp   = 2'd2;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        regWrite = 1'b1;
        pcUpdate = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA = 1'b1;
        aluOp   = 2'd1;
        unique case (funct3)
          3'b000:  begin pcUpdate = 1'b1; pcSrc = alu_zero;  state_d = S_FETCH; end
          3'b001:  begin pcUpdate = 1'b1; pcSrc = !alu_zero; state_d = S_FETCH; end
          default: begin state_d = S_TRAP; illegal_d = 1'b1; end
        endcase
      end
      S_JAL: begin
        regWrite  = 1'b1;
        resultSrc = 2'd2;
        pcUpdate  = 1'b1;
        pcSrc     = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are gated by reset so nothing strobes while the core is held in reset.
  assign cfsm__pc_update  = reset & pcUpdate;
  assign cfsm__pc_src     = reset & pcSrc;
  assign cfsm__ir_write   = reset & irWrite;
  assign cfsm__reg_write  = reset & regWrite;
  assign cfsm__mem_read   = reset & memRead;
  assign cfsm__mem_write  = reset & memWrite;
  assign cfsm__alu_src_a  = reset & aluSrcA;
  assign cfsm__alu_src_b  = reset ? aluSrcB : 2'd0;
  assign cfsm__alu_op     = reset ? aluOp : 2'd0;
  assign cfsm__result_src = reset ? resultSrc : 2'd0;
  assign illegal_instr    = illegal_q;
  assign bus_error        = busErr_q;
  assign retired          = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm: randomized instruction stream scored against a
// per-instruction-class reference model, plus directed trap and reset scenarios.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_update, pc_src, ir_write, reg_write, mem_read, mem_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, result_src;
  logic        illegal_instr, bus_error;
  logic [31:0] retired;

  control_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .cfsm__pc_update(pc_update), .cfsm__pc_src(pc_src), .cfsm__ir_write(ir_write),
    .cfsm__reg_write(reg_write), .cfsm__mem_read(mem_read), .cfsm__mem_write(mem_write),
    .cfsm__alu_src_a(alu_src_a), .cfsm__alu_src_b(alu_src_b), .cfsm__alu_op(alu_op),
    .cfsm__result_src(result_src), .illegal_instr(illegal_instr), .bus_error(bus_error),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        pcSrc;
    logic        regWrite;
    logic [1:0]  resultSrc;
    logic        memWrite;
    logic        aluA;
    logic [1:0]  aluOp;
    int          memReads;
    logic [31:0] retired;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;
  int          checks = 0, errors = 0;
  int          monChecks = 0, monErrors = 0;
  int          startCyc = 0;
  logic [31:0] expRetired = 32'd0;
  int          monCyc = 0, irCnt = 0, rdCnt = 0;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic logic [31:0] strobes();
    return {19'd0, pc_update, pc_src, ir_write, reg_write, mem_read, mem_write,
            alu_src_a, alu_src_b, alu_op, result_src};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic scoreCheck(input string name, input logic [31:0] actual, input logic [31:0] expected);
    monChecks++;
    if (actual !== expected) begin
      monErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, monCyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every retirement pulse pops one expectation and compares the whole event.
  always @(negedge clk) begin
    if (!reset) begin
      monCyc = 0;
      irCnt  = 0;
      rdCnt  = 0;
    end else begin
      if (ir_write) irCnt++;
      if (mem_read) rdCnt++;
      if (pc_update) begin
        if (expQ.size() == 0) begin
          scoreCheck("unexpected_pc_update", 32'(pc_update), 32'd0);
        end else begin
          monE = expQ.pop_front();
          scoreCheck("event_cycle", 32'(monCyc), 32'(monE.cyc));
          scoreCheck("pc_src", 32'(pc_src), 32'(monE.pcSrc));
          scoreCheck("reg_write", 32'(reg_write), 32'(monE.regWrite));
          scoreCheck("result_src", 32'(result_src), 32'(monE.resultSrc));
          scoreCheck("mem_write", 32'(mem_write), 32'(monE.memWrite));
          scoreCheck("alu_src_a", 32'(alu_src_a), 32'(monE.aluA));
          scoreCheck("alu_src_b", 32'(alu_src_b), 32'd0);
          scoreCheck("alu_op", 32'(alu_op), 32'(monE.aluOp));
          scoreCheck("retired", retired, monE.retired);
          scoreCheck("ir_write_cycles", 32'(irCnt), 32'd1);
          scoreCheck("mem_read_cycles", 32'(rdCnt), 32'(monE.memReads));
        end
        irCnt = 0;
        rdCnt = 0;
      end else begin
        scoreCheck("pc_src_without_update", 32'(pc_src), 32'd0);
      end
      monCyc++;
    end
  end

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkOutput("reset_strobes", strobes(), 32'd0);
    checkOutput("reset_retired", retired, 32'd0);
    checkOutput("reset_flags", {30'd0, illegal_instr, bus_error}, 32'd0);
    expQ.delete();
    startCyc   = 0;
    expRetired = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Reference model: class -> latency and retirement-cycle strobes; then drive the cycles.
  // cls: 0 R, 1 I, 2 load, 3 store, 4 branch (BEQ/BNE), 5 JAL.
  task automatic applyStimulus(input int cls, input int waits);
    logic [6:0] op;
    logic [2:0] f3;
    logic       az;
    int         lat;
    exp_t       e;
    az = 1'($urandom_range(0, 1));
    f3 = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b000;
    e.pcSrc = 1'b0; e.regWrite = 1'b0; e.resultSrc = 2'd0; e.memWrite = 1'b0;
    e.aluA = 1'b0; e.aluOp = 2'd0; e.memReads = 0;
    case (cls)
      0:       begin op = 7'b0110011; lat = 4; e.regWrite = 1'b1; end
      1:       begin op = 7'b0010011; lat = 4; e.regWrite = 1'b1; end
      2:       begin op = OP_LOAD; lat = 5 + waits; e.regWrite = 1'b1; e.resultSrc = 2'd1;
                     e.memReads = waits + 1; end
      3:       begin op = OP_STORE; lat = 4 + waits; e.memWrite = 1'b1; end
      4:       begin op = OP_BRANCH; lat = 3; e.aluA = 1'b1; e.aluOp = 2'd1;
                     e.pcSrc = (f3 == 3'b000) ? az : !az; end
      default: begin op = 7'b1101111; lat = 3; e.regWrite = 1'b1; e.resultSrc = 2'd2;
                     e.pcSrc = 1'b1; end
    endcase
    e.cyc     = startCyc + lat - 1;
    e.retired = expRetired;
    expQ.push_back(e);
    expRetired = expRetired + 32'd1;
    startCyc   = startCyc + lat;
    for (int k = 0; k < lat; k++) begin
      opcode   = (k == 1) ? op : 7'($urandom);
      funct3   = (k == 2 && cls == 4) ? f3 : 3'($urandom);
      alu_zero = (k == 2) ? az : 1'($urandom);
      if ((cls == 2 || cls == 3) && k >= 3) mem_ready = (k == 3 + waits);
      else mem_ready = 1'($urandom);
      tick();
    end
  endtask

  initial begin
    int wr, bad;
    logic busAt18;
    doReset();

    // Three back-to-back R-types: 12 cycles, three retirements.
    repeat (3) applyStimulus(0, 0);
    checkOutput("retired_after_3R", retired, expRetired);

    applyStimulus(2, 3);
    applyStimulus(4, 0);
    applyStimulus(5, 0);
    repeat (60) applyStimulus(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("retired_total", retired, expRetired);

    // Reset asserted while a load is waiting on memory.
    for (int c = 0; c < 6; c++) begin
      opcode    = (c == 1) ? OP_LOAD : 7'($urandom);
      mem_ready = (c >= 3) ? 1'b0 : 1'($urandom);
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midload_reset_strobes", strobes(), 32'd0);
    checkOutput("midload_reset_retired", retired, 32'd0);
    checkOutput("midload_reset_flags", {30'd0, illegal_instr, bus_error}, 32'd0);
    expQ.delete();
    startCyc   = 0;
    expRetired = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ir_write_after_reset", 32'(ir_write), 32'd1);
    tick();

    // Unsupported opcode traps.
    doReset();
    for (int c = 0; c < 8; c++) begin
      opcode    = (c == 1) ? 7'b1111111 : 7'($urandom);
      mem_ready = 1'($urandom);
      tick();
    end
    checkOutput("illegal_opcode_flag", 32'(illegal_instr), 32'd1);
    checkOutput("illegal_opcode_buserr", 32'(bus_error), 32'd0);
    checkOutput("illegal_opcode_retired", retired, 32'd0);

    // Branch with unsupported funct3 traps without retiring.
    doReset();
    applyStimulus(0, 0);
    for (int c = 0; c < 6; c++) begin
      opcode   = (c == 1) ? OP_BRANCH : 7'($urandom);
      funct3   = (c == 2) ? 3'b100 : 3'($urandom);
      alu_zero = 1'($urandom);
      tick();
    end
    checkOutput("bad_branch_flag", 32'(illegal_instr), 32'd1);
    checkOutput("bad_branch_retired", retired, expRetired);

    // Store with memory never ready: 16 write cycles, then a sticky bus-error trap.
    doReset();
    wr = 0;
    bad = 0;
    busAt18 = 1'b0;
    for (int c = 0; c < 70; c++) begin
      opcode    = (c == 1) ? OP_STORE : 7'($urandom);
      mem_ready = 1'b0;
      @(negedge clk);
      if (mem_write) wr++;
      if (c >= 19 && strobes() != 32'd0) bad++;
      if (c == 18) busAt18 = bus_error;
      tick();
    end
    checkOutput("timeout_write_cycles", 32'(wr), 32'd16);
    checkOutput("timeout_flag_before_trap", 32'(busAt18), 32'd0);
    checkOutput("trap_strobes_cycles", 32'(bad), 32'd0);
    checkOutput("timeout_bus_error", 32'(bus_error), 32'd1);
    checkOutput("timeout_illegal", 32'(illegal_instr), 32'd0);

    // Only reset leaves the trap.
    doReset();
    applyStimulus(5, 0);
    applyStimulus(3, 2);
    checkOutput("final_queue_drained", 32'(expQ.size()), 32'd0);

    repeat (2) tick();
    checks = checks + monChecks;
    errors = errors + monErrors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
